// File: rtl/job_sequencer.sv
// Job sequencer: fetches dimension/cell counts from the register map, then
// walks every (cell, dim) element index through a valid/ready handshake.
module job_sequencer #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int IDX_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    output logic                  cfg_rd_en,
    output logic [ADDR_WIDTH-1:0] cfg_rd_addr,
    input  logic [DATA_WIDTH-1:0] cfg_rd_data,
    output logic                  elem_valid,
    input  logic                  elem_ready,
    output logic [IDX_WIDTH-1:0]  elem_cell,
    output logic [IDX_WIDTH-1:0]  elem_dim,
    output logic                  elem_last,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [IDX_WIDTH-1:0]  cells_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH_DIM,
        S_FETCH_CELL,
        S_CAPTURE,
        S_CHECK,
        S_RUN,
        S_FINISH
    } state_t;

    localparam logic [DATA_WIDTH-1:0] ONE       = DATA_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0] DIM_MAX   = DATA_WIDTH'(50000);
    localparam logic [IDX_WIDTH-1:0]  IDX_ONE   = IDX_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_DIM  = '0;
    localparam logic [ADDR_WIDTH-1:0] ADDR_CELL = ADDR_WIDTH'(1);

    state_t                  state_q;
    logic [DATA_WIDTH-1:0]   dim_cfg_q;
    logic [DATA_WIDTH-1:0]   cell_cfg_q;
    logic [IDX_WIDTH-1:0]    elem_cell_q, elem_cell_d;
    logic [IDX_WIDTH-1:0]    elem_dim_q, elem_dim_d;
    logic [IDX_WIDTH-1:0]    cells_done_q, cells_done_d;
    logic [ADDR_WIDTH-1:0]   rd_addr_q;
    logic                    rd_en_q;
    logic                    valid_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    err_q;

    logic hs;
    logic dim_last;
    logic cell_last;
    logic cfg_bad;

    assign hs        = valid_q && elem_ready;
    assign dim_last  = (DATA_WIDTH'(elem_dim_q) == dim_cfg_q - ONE);
    assign cell_last = (DATA_WIDTH'(elem_cell_q) == cell_cfg_q - ONE);

    // Cell count must fit the index counters so the walk never wraps.
    assign cfg_bad = (dim_cfg_q == '0) || (dim_cfg_q > DIM_MAX) ||
                     (cell_cfg_q == '0) ||
                     ((cell_cfg_q >> IDX_WIDTH) != '0);

    always_comb begin
        elem_dim_d   = elem_dim_q;
        elem_cell_d  = elem_cell_q;
        cells_done_d = cells_done_q;
        if (hs) begin
            if (dim_last) begin
                elem_dim_d   = '0;
                elem_cell_d  = elem_cell_q + IDX_ONE;
                cells_done_d = cells_done_q + IDX_ONE;
            end else begin
                elem_dim_d = elem_dim_q + IDX_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            dim_cfg_q    <= '0;
            cell_cfg_q   <= '0;
            elem_cell_q  <= '0;
            elem_dim_q   <= '0;
            cells_done_q <= '0;
            rd_addr_q    <= '0;
            rd_en_q      <= 1'b0;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            done_q       <= 1'b0;
            rd_en_q      <= 1'b0;
            rd_addr_q    <= '0;
            elem_dim_q   <= elem_dim_d;
            elem_cell_q  <= elem_cell_d;
            cells_done_q <= cells_done_d;
            // Abort wins over everything, but a coincident handshake still counts.
            if (abort && state_q != S_IDLE) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
                valid_q <= 1'b0;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        if (start && !abort) begin
                            err_q        <= 1'b0;
                            cells_done_q <= '0;
                            busy_q       <= 1'b1;
                            rd_en_q      <= 1'b1;
                            rd_addr_q    <= ADDR_DIM;
                            state_q      <= S_FETCH_DIM;
                        end
                    end
                    S_FETCH_DIM: begin
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= ADDR_CELL;
                        state_q   <= S_FETCH_CELL;
                    end
                    S_FETCH_CELL: begin
                        dim_cfg_q <= cfg_rd_data;
                        state_q   <= S_CAPTURE;
                    end
                    S_CAPTURE: begin
                        cell_cfg_q <= cfg_rd_data;
                        state_q    <= S_CHECK;
                    end
                    S_CHECK: begin
                        if (cfg_bad) begin
                            err_q   <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= S_FINISH;
                        end else begin
                            elem_cell_q <= '0;
                            elem_dim_q  <= '0;
                            valid_q     <= 1'b1;
                            state_q     <= S_RUN;
                        end
                    end
                    S_RUN: begin
                        if (hs && dim_last && cell_last) begin
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_FINISH;
                        end
                    end
                    S_FINISH: begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                    default: begin
                        busy_q  <= 1'b0;
                        valid_q <= 1'b0;
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign cfg_rd_en   = rd_en_q;
    assign cfg_rd_addr = rd_addr_q;
    assign elem_valid  = valid_q;
    assign elem_cell   = elem_cell_q;
    assign elem_dim    = elem_dim_q;
    assign elem_last   = valid_q && dim_last;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign cells_done  = cells_done_q;

endmodule

// File: tb/tb_job_sequencer.sv
// Directed + randomized bench for job_sequencer against a nested-loop
// reference of the expected element walk.
module tb_job_sequencer;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int IW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          elem_ready = 1'b0;
    logic          cfg_rd_en;
    logic [AW-1:0] cfg_rd_addr;
    logic [DW-1:0] cfg_rd_data = '0;
    logic          elem_valid;
    logic [IW-1:0] elem_cell;
    logic [IW-1:0] elem_dim;
    logic          elem_last;
    logic          busy;
    logic          done;
    logic          err;
    logic [IW-1:0] cells_done;

    int total = 0;
    int bad = 0;
    logic [DW-1:0] regmap [2];
    int rd_log[$];

    job_sequencer #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .IDX_WIDTH (IW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .cfg_rd_en  (cfg_rd_en),
        .cfg_rd_addr(cfg_rd_addr),
        .cfg_rd_data(cfg_rd_data),
        .elem_valid (elem_valid),
        .elem_ready (elem_ready),
        .elem_cell  (elem_cell),
        .elem_dim   (elem_dim),
        .elem_last  (elem_last),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .cells_done (cells_done)
    );

    always #5 clk = ~clk;

    // Register map with one-cycle read latency.
    always @(posedge clk) begin
        if (cfg_rd_en) begin
            cfg_rd_data <= regmap[cfg_rd_addr[0]];
            rd_log.push_back(int'(cfg_rd_addr));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk(tag, {busy, done, err, elem_valid, elem_last, cfg_rd_en,
                  cfg_rd_addr, elem_cell, elem_dim, cells_done}, 64'd0);
    endtask

    // mode: 0 ready tied high, 1 ready toggles 1-0-1-0, 2 random ready
    task automatic run_job(input string nm, input int d, input int c,
                           input int mode, input int kill_at,
                           input bit kill_rst, input bit start_noise);
        int eq_c[$];
        int eq_d[$];
        bit eq_l[$];
        bit cfg_bad;
        bit killed;
        bit saw_valid;
        bit hold;
        bit finished;
        int hs_n;
        int done_n;
        int cyc;
        int budget;
        logic [IW-1:0] h_cell, h_dim, x_cell, x_dim;
        logic h_last, x_last;
        killed = 0; saw_valid = 0; hold = 0; finished = 0;
        hs_n = 0; done_n = 0; cyc = 0;
        h_cell = '0; h_dim = '0; h_last = 0;
        cfg_bad = (d == 0) || (d > 50000) || (c == 0) || (c > 65535);
        if (!cfg_bad)
            for (int ci = 0; ci < c; ci++)
                for (int di = 0; di < d; di++) begin
                    eq_c.push_back(ci);
                    eq_d.push_back(di);
                    eq_l.push_back(di == d - 1);
                end
        budget = cfg_bad ? 20 : d * c * 4 + 20;
        regmap[0] = d;
        regmap[1] = c;
        rd_log.delete();
        start = 1'b1;
        step();
        start = 1'b0;
        chk({nm, ".busy_on_start"}, busy, 1);
        while (!finished && cyc < budget) begin
            if (mode == 0) elem_ready = 1'b1;
            else if (mode == 1) elem_ready = (cyc % 2 == 0);
            else elem_ready = 1'($urandom % 2);
            start = start_noise ? 1'($urandom % 2) : 1'b0;
            if (kill_at >= 0 && hs_n == kill_at && elem_valid) begin
                if (kill_rst) rst = 1'b1;
                else abort = 1'b1;
                killed = 1;
            end
            if (hold)
                chk({nm, ".stall_stable"},
                    {elem_valid, elem_cell, elem_dim, elem_last},
                    {1'b1, h_cell, h_dim, h_last});
            if (elem_valid) saw_valid = 1;
            hold = elem_valid && !elem_ready;
            h_cell = elem_cell;
            h_dim = elem_dim;
            h_last = elem_last;
            if (elem_valid && elem_ready) begin
                chk({nm, ".hs_expected"}, eq_c.size() > 0, 1);
                if (eq_c.size() > 0) begin
                    x_cell = IW'(eq_c.pop_front());
                    x_dim = IW'(eq_d.pop_front());
                    x_last = eq_l.pop_front();
                    chk({nm, ".idx"}, {elem_cell, elem_dim, elem_last},
                        {x_cell, x_dim, x_last});
                end
                hs_n++;
            end
            step();
            cyc++;
            if (killed) begin
                chk({nm, ".kill_idle"}, {busy, elem_valid, done}, 0);
                if (kill_rst) chk_reset({nm, ".kill_rst"});
                rst = 1'b0;
                abort = 1'b0;
                finished = 1;
            end else begin
                if (done) done_n++;
                if (!busy) finished = 1;
            end
        end
        start = 1'b0;
        elem_ready = 1'b0;
        chk({nm, ".no_timeout"}, finished, 1);
        chk({nm, ".done_pulses"}, done_n, killed ? 0 : 1);
        chk({nm, ".saw_valid"}, saw_valid, !cfg_bad);
        if (!killed) begin
            chk({nm, ".hs_count"}, hs_n, cfg_bad ? 0 : d * c);
            chk({nm, ".err"}, err, cfg_bad);
            chk({nm, ".cells_done"}, cells_done, cfg_bad ? 0 : c);
            chk({nm, ".rd_count"}, rd_log.size(), 2);
            if (rd_log.size() == 2)
                chk({nm, ".rd_addrs"}, {rd_log[0], rd_log[1]}, {32'd0, 32'd1});
            if (cfg_bad) chk({nm, ".err_len"}, cyc, 5);
        end else if (!kill_rst) begin
            chk({nm, ".abort_cells"}, cells_done, hs_n / d);
        end
    endtask

    initial begin
        int rd;
        int rc;
        regmap[0] = '0;
        regmap[1] = '0;
        rst = 1'b1;
        step();
        step();
        chk_reset("reset_state");
        rst = 1'b0;
        step();
        chk_reset("idle_after_reset");

        run_job("basic", 3, 2, 0, -1, 0, 0);
        run_job("toggle", 3, 2, 1, -1, 0, 0);
        run_job("dim0", 0, 2, 0, -1, 0, 0);
        run_job("dim50001", 50001, 2, 0, -1, 0, 0);
        run_job("cell0", 3, 0, 0, -1, 0, 0);
        run_job("cellhi", 3, 65536, 0, -1, 0, 0);
        run_job("abort", 3, 2, 0, 4, 0, 0);
        run_job("rerun", 3, 2, 0, -1, 0, 0);
        run_job("startnoise", 3, 2, 2, -1, 0, 1);

        start = 1'b1;
        abort = 1'b1;
        step();
        chk("start_abort_idle", {busy, cfg_rd_en}, 0);
        chk("cells_done_kept", cells_done, 2);
        start = 1'b0;
        abort = 1'b0;
        step();
        chk("still_idle", busy, 0);

        run_job("rst_mid_run", 3, 2, 0, 3, 1, 0);
        run_job("after_rst", 2, 3, 2, -1, 0, 0);

        for (int k = 0; k < 4; k++) begin
            rd = $urandom_range(1, 5);
            rc = $urandom_range(1, 5);
            run_job($sformatf("rand%0d", k), rd, rc, 2, -1, 0, 0);
        end
        run_job("rand_abort", 4, 3, 2, 5, 0, 0);

        run_job("max_cells", 1, 65535, 0, -1, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
